// File: rtl/meteor_game_ctrl.sv
// ---------------------------------------------------------------------------
// meteor_game_ctrl
//   Central game sequencer for the meteor shooter. Owns the per-meteor alive
//   mask, arbitrates bullet/meteor collisions (at most one kill per cycle),
//   keeps score and miss counts and runs the IDLE/ARM/RUN/WIN/LOSE flow.
//
// Ports
//   i_Clk          system/pixel clock
//   i_Rst          synchronous reset, active high
//   i_GameStart    level-sensitive start request (honoured in IDLE only)
//   i_FrameTick    one-cycle pulse per video frame
//   i_BullValid    bullet is in flight
//   i_BullX/Y      bullet column/row
//   i_MeteX/Y      packed meteor columns/rows, meteor i at [i*COORD_W +: COORD_W]
//   o_GameActive   high while in RUN
//   o_MeteAlive    per-meteor alive / draw enable
//   o_MeteRespawn  1-cycle pulse in ARM, meteorites reload start positions
//   o_BullKill     1-cycle pulse, bullet must return to the ship
//   o_Score        kill count, saturates at 99
//   o_Misses       miss count
//   o_State        IDLE=0, ARM=1, RUN=2, WIN=3, LOSE=4
// All outputs are registered.
// ---------------------------------------------------------------------------
module meteor_game_ctrl #(
  parameter int N_METEORS   = 8,
  parameter int COORD_W     = 6,
  parameter int FLOOR_ROW   = 28,
  parameter int TOP_ROW     = 1,
  parameter int MAX_MISSES  = 3,
  parameter int HOLD_FRAMES = 60,
  parameter logic [N_METEORS-1:0] METE_EN = '1
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic                           i_GameStart,
  input  logic                           i_FrameTick,
  input  logic                           i_BullValid,
  input  logic [COORD_W-1:0]             i_BullX,
  input  logic [COORD_W-1:0]             i_BullY,
  input  logic [N_METEORS*COORD_W-1:0]   i_MeteX,
  input  logic [N_METEORS*COORD_W-1:0]   i_MeteY,
  output logic                           o_GameActive,
  output logic [N_METEORS-1:0]           o_MeteAlive,
  output logic                           o_MeteRespawn,
  output logic                           o_BullKill,
  output logic [6:0]                     o_Score,
  output logic [3:0]                     o_Misses,
  output logic [2:0]                     o_State
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_WIN  = 3'd3,
    S_LOSE = 3'd4
  } state_e;

  localparam logic [COORD_W-1:0]   FLOOR_C     = COORD_W'(FLOOR_ROW);
  localparam logic [COORD_W-1:0]   TOP_C       = COORD_W'(TOP_ROW);
  localparam logic [3:0]           MAX_MISS_C  = 4'(MAX_MISSES);
  localparam logic [7:0]           HOLD_LAST_C = 8'(HOLD_FRAMES - 1);
  localparam logic [6:0]           SCORE_MAX_C = 7'd99;
  localparam logic [N_METEORS-1:0] ONE_N       = N_METEORS'(1);

  // Registered state
  state_e                 state_q, state_d;
  logic [N_METEORS-1:0]   alive_q, alive_d;
  logic [6:0]             score_q, score_d;
  logic [3:0]             misses_q, misses_d;
  logic                   kill_q, kill_d;
  logic                   respawn_q, respawn_d;
  logic                   active_q, active_d;
  logic [7:0]             hold_q, hold_d;
  logic                   lockout_q, lockout_d;

  // Per-meteor collision terms
  logic [N_METEORS-1:0]   ground_vec;
  logic [N_METEORS-1:0]   hit_vec;
  logic [N_METEORS-1:0]   grant_oh;
  logic                   miss_ev;
  logic [3:0]             misses_inc;

  for (genvar gi = 0; gi < N_METEORS; gi++) begin : g_mete
    logic [COORD_W-1:0] mx;
    logic [COORD_W-1:0] my;
    assign mx = i_MeteX[gi*COORD_W +: COORD_W];
    assign my = i_MeteY[gi*COORD_W +: COORD_W];
    // Only live, populated meteors can touch the floor or be hit.
    assign ground_vec[gi] = alive_q[gi] & METE_EN[gi] & (my >= FLOOR_C);
    assign hit_vec[gi]    = alive_q[gi] & METE_EN[gi] & i_BullValid & ~lockout_q
                            & (mx == i_BullX) & (my == i_BullY);
  end

  // Lowest set bit wins: x & -x isolates it.
  assign grant_oh   = hit_vec & (~hit_vec + ONE_N);
  assign miss_ev    = i_BullValid & ~lockout_q & (i_BullY == TOP_C);
  assign misses_inc = misses_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    alive_d   = alive_q;
    score_d   = score_q;
    misses_d  = misses_q;
    kill_d    = 1'b0;
    hold_d    = hold_q;
    // Lockout survives only while the same bullet stays in flight, so one
    // flight yields at most one kill or miss.
    lockout_d = lockout_q & i_BullValid;

    case (state_q)
      S_IDLE: begin
        if (i_GameStart) begin
          state_d  = S_ARM;
          alive_d  = METE_EN;
          score_d  = 7'd0;
          misses_d = 4'd0;
        end
      end

      S_ARM: begin
        state_d = S_RUN;
      end

      S_RUN: begin
        hold_d = 8'd0;
        if (alive_q == '0) begin
          // Registered mask already empty: the last kill happened last cycle.
          state_d = S_WIN;
        end else if (|ground_vec) begin
          state_d = S_LOSE;
        end else if (|hit_vec) begin
          alive_d   = alive_q & ~grant_oh;
          kill_d    = 1'b1;
          lockout_d = 1'b1;
          score_d   = (score_q < SCORE_MAX_C) ? score_q + 7'd1 : score_q;
        end else if (miss_ev) begin
          kill_d    = 1'b1;
          lockout_d = 1'b1;
          misses_d  = misses_inc;
          if (misses_inc == MAX_MISS_C) begin
            state_d = S_LOSE;
          end
        end
      end

      S_WIN, S_LOSE: begin
        if (state_q == S_WIN) begin
          alive_d = '0;
        end
        if (i_FrameTick) begin
          if (hold_q == HOLD_LAST_C) begin
            hold_d  = 8'd0;
            state_d = S_IDLE;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs that track the state are registered alongside it.
    respawn_d = (state_d == S_ARM);
    active_d  = (state_d == S_RUN);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= S_IDLE;
      alive_q   <= '0;
      score_q   <= 7'd0;
      misses_q  <= 4'd0;
      kill_q    <= 1'b0;
      respawn_q <= 1'b0;
      active_q  <= 1'b0;
      hold_q    <= 8'd0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alive_q   <= alive_d;
      score_q   <= score_d;
      misses_q  <= misses_d;
      kill_q    <= kill_d;
      respawn_q <= respawn_d;
      active_q  <= active_d;
      hold_q    <= hold_d;
      lockout_q <= lockout_d;
    end
  end

  assign o_State       = state_q;
  assign o_GameActive  = active_q;
  assign o_MeteAlive   = alive_q;
  assign o_MeteRespawn = respawn_q;
  assign o_BullKill    = kill_q;
  assign o_Score       = score_q;
  assign o_Misses      = misses_q;

endmodule

// File: tb/tb_meteor_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_meteor_game_ctrl
//   Scoreboard bench for meteor_game_ctrl: each stimulus step pushes the
//   outputs it expects after the next clock edge; the queue is drained and
//   compared 1 ns after that edge.
// ---------------------------------------------------------------------------
module tb_meteor_game_ctrl;

  localparam int N  = 8;
  localparam int CW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            game_start;
  logic            frame_tick;
  logic            bull_valid;
  logic [CW-1:0]   bull_x;
  logic [CW-1:0]   bull_y;
  logic [N*CW-1:0] mete_x;
  logic [N*CW-1:0] mete_y;
  logic            game_active;
  logic [N-1:0]    mete_alive;
  logic            mete_respawn;
  logic            bull_kill;
  logic [6:0]      score;
  logic [3:0]      misses;
  logic [2:0]      state;

  logic [CW-1:0]   mx [N];
  logic [CW-1:0]   my [N];

  always #5 clk = ~clk;

  always_comb begin
    mete_x = '0;
    mete_y = '0;
    for (int i = 0; i < N; i++) begin
      mete_x[i*CW +: CW] = mx[i];
      mete_y[i*CW +: CW] = my[i];
    end
  end

  meteor_game_ctrl dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_GameStart   (game_start),
    .i_FrameTick   (frame_tick),
    .i_BullValid   (bull_valid),
    .i_BullX       (bull_x),
    .i_BullY       (bull_y),
    .i_MeteX       (mete_x),
    .i_MeteY       (mete_y),
    .o_GameActive  (game_active),
    .o_MeteAlive   (mete_alive),
    .o_MeteRespawn (mete_respawn),
    .o_BullKill    (bull_kill),
    .o_Score       (score),
    .o_Misses      (misses),
    .o_State       (state)
  );

  typedef struct {
    string       tag;
    int unsigned exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [N-1:0] exp_alive;
  int unsigned  exp_score;
  int unsigned  exp_misses;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned observe(input string tag);
    case (tag)
      "state":   return int'(state);
      "alive":   return int'(mete_alive);
      "score":   return int'(score);
      "misses":  return int'(misses);
      "kill":    return int'(bull_kill);
      "respawn": return int'(mete_respawn);
      "active":  return int'(game_active);
      default:   return 32'hDEAD;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int unsigned v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  // One clock: sample 1 ns after the edge, then compare everything queued.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, observe(e.tag), e.exp);
    end
  endtask

  task automatic place_default();
    for (int i = 0; i < N; i++) begin
      mx[i] = CW'(i * 4 + 2);
      my[i] = CW'(5);
    end
  endtask

  task automatic start_game();
    $display("txn: start game");
    game_start = 1'b1;
    expect_out("state", 1);
    expect_out("respawn", 1);
    expect_out("active", 0);
    cycle();
    game_start = 1'b0;
    exp_alive  = 8'hFF;
    exp_score  = 0;
    exp_misses = 0;
    expect_out("state", 2);
    expect_out("respawn", 0);
    expect_out("active", 1);
    expect_out("alive", exp_alive);
    expect_out("score", 0);
    expect_out("misses", 0);
    cycle();
  endtask

  // Fire at meteor idx's position for one cycle, then drop the bullet.
  task automatic shoot(input int idx, input int unsigned rel_state);
    $display("txn: shoot meteor %0d", idx);
    bull_x     = mx[idx];
    bull_y     = my[idx];
    bull_valid = 1'b1;
    exp_alive[idx] = 1'b0;
    exp_score++;
    expect_out("kill", 1);
    expect_out("alive", exp_alive);
    expect_out("score", exp_score);
    expect_out("state", 2);
    cycle();
    bull_valid = 1'b0;
    expect_out("kill", 0);
    expect_out("state", rel_state);
    cycle();
  endtask

  // HOLD_FRAMES frame pulses; the state stays put until the 60th.
  task automatic hold_ticks(input int unsigned cur);
    $display("txn: %0d frame ticks in state %0d", 60, cur);
    for (int k = 1; k <= 60; k++) begin
      game_start = (k <= 3);  // must be ignored in WIN/LOSE
      frame_tick = 1'b1;
      expect_out("state", (k == 60) ? 0 : cur);
      if (k == 60) expect_out("score", exp_score);
      cycle();
      frame_tick = 1'b0;
      game_start = 1'b0;
      cycle();
    end
  endtask

  initial begin
    rst        = 1'b1;
    game_start = 1'b0;
    frame_tick = 1'b0;
    bull_valid = 1'b0;
    bull_x     = '0;
    bull_y     = '0;
    exp_alive  = '0;
    exp_score  = 0;
    exp_misses = 0;
    place_default();

    // Reset state
    $display("txn: reset");
    cycle();
    expect_out("state", 0);
    expect_out("alive", 0);
    expect_out("score", 0);
    expect_out("misses", 0);
    expect_out("kill", 0);
    expect_out("respawn", 0);
    expect_out("active", 0);
    cycle();
    rst = 1'b0;
    expect_out("state", 0);
    cycle();

    // T2 start, then T1 reset mid-RUN with 3 meteors alive
    start_game();
    for (int i = 0; i < 5; i++) shoot(i, 2);
    expect_out("alive", 8'hE0);
    cycle();
    $display("txn: reset mid-RUN");
    rst = 1'b1;
    expect_out("state", 0);
    expect_out("alive", 0);
    expect_out("score", 0);
    expect_out("active", 0);
    cycle();
    rst = 1'b0;
    expect_out("state", 0);
    cycle();

    // T3 arbitration: meteors 2 and 5 both at (10,12)
    start_game();
    $display("txn: double hit at (10,12)");
    mx[2] = 6'd10; my[2] = 6'd12;
    mx[5] = 6'd10; my[5] = 6'd12;
    bull_x = 6'd10; bull_y = 6'd12; bull_valid = 1'b1;
    exp_alive[2] = 1'b0;
    exp_score    = 1;
    expect_out("kill", 1);
    expect_out("alive", exp_alive);
    expect_out("score", 1);
    cycle();
    for (int k = 0; k < 2; k++) begin
      expect_out("kill", 0);
      expect_out("alive", exp_alive);
      expect_out("score", 1);
      cycle();
    end
    bull_valid = 1'b0;
    expect_out("kill", 0);
    cycle();
    shoot(5, 2);

    // T4 win: remaining meteors, last one flips to WIN two edges after it
    shoot(0, 2);
    shoot(1, 2);
    shoot(3, 2);
    shoot(4, 2);
    shoot(6, 2);
    shoot(7, 3);
    expect_out("alive", 0);
    expect_out("score", 8);
    expect_out("active", 0);
    expect_out("state", 3);
    cycle();
    hold_ticks(3);

    // T5 ground beats hit; Y=27 is still above the floor
    place_default();
    start_game();
    $display("txn: meteor 3 at Y=27");
    my[3] = 6'd27;
    expect_out("state", 2);
    cycle();
    $display("txn: ground and hit in same cycle");
    my[3] = 6'd28;
    bull_x = mx[0]; bull_y = my[0]; bull_valid = 1'b1;
    expect_out("state", 4);
    expect_out("kill", 0);
    expect_out("score", 0);
    expect_out("alive", 8'hFF);
    expect_out("active", 0);
    cycle();
    bull_valid = 1'b0;
    expect_out("alive", 8'hFF);
    expect_out("kill", 0);
    cycle();
    hold_ticks(4);
    my[3] = 6'd5;

    // T6 misses with the bullet held valid through each flight
    start_game();
    for (int b = 0; b < 3; b++) begin
      $display("txn: miss flight %0d", b);
      bull_x = 6'd39; bull_y = 6'd0; bull_valid = 1'b1;
      expect_out("kill", 0);
      cycle();
      bull_y = 6'd1;
      exp_misses++;
      expect_out("kill", 1);
      expect_out("misses", exp_misses);
      expect_out("state", (b == 2) ? 4 : 2);
      cycle();
      expect_out("kill", 0);
      expect_out("misses", exp_misses);
      cycle();
      bull_valid = 1'b0;
      expect_out("kill", 0);
      cycle();
    end
    expect_out("state", 4);
    expect_out("misses", 3);
    expect_out("alive", 8'hFF);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
